csa_accumulator: RTL and testbench
==================================

Name: csa_accumulator

Overview:
- Upstream stage of the m-operand fast adder. Accepts one WIDTH-bit operand per cycle on a valid/ready stream.
- Folds each operand into a redundant sum/carry register pair through a 3:2 carry-save compressor. No carry propagation happens inside this block.
- At group end, presents the (sum, carry) pair downstream for the carry-propagate adder, which forms the final total.
- The group total equals out_s + out_c mod 2^WIDTH.

Parameters:
- WIDTH, 64, operand and output vector width in bits.
- M, 8, maximum operands per group (M >= 2).
- CW, $clog2(M+1), width of out_count. Derived; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand.
- in_last  input  1  this operand closes the group; qualified by the in handshake.
- out_valid  output  1  sum/carry pair presented.
- out_ready  input  1  downstream accepts the pair.
- out_s  output  WIDTH  redundant sum vector.
- out_c  output  WIDTH  redundant carry vector, already left-aligned (bit 0 = 0).
- out_count  output  CW  number of operands in the presented group.

Behaviour:
- Reset, checked at the rising edge of clk with rst_n = 0:
  - state = ACCUM; s = 0, c = 0, count = 0.
  - out_valid = 0, in_ready = 1, out_s = 0, out_c = 0, out_count = 0.
  - Reset overrides any handshake in the same cycle. A partial group or a held result is discarded.
- In handshake (fire_in = in_valid & in_ready):
  - s <= s ^ c ^ in_data.
  - c <= {maj(s, c, in_data)[WIDTH-2:0], 1'b0}, where maj = (s&c)|(s&x)|(c&x).
  - The maj bit WIDTH-1 is discarded.
  - count <= count + 1.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
    - On fire_in with in_last = 1 or count+1 == M: update s, c and count, then go to HOLD the next cycle.
    - Otherwise stay in ACCUM.
  - HOLD: in_ready = 0, out_valid = 1. out_s = s, out_c = c, out_count = count, all held stable until the out handshake.
    - On out_valid & out_ready: s, c and count clear to 0 and state goes to ACCUM.
    - in_ready rises the cycle after the out handshake.
- Latency: out_valid asserts the cycle after the closing operand is accepted. Minimum group period is count + 1 cycles.
- An in_valid = 1 with in_last = 1 on the first operand gives a one-operand group: out_s = operand, out_c = 0, out_count = 1.
- The M limit closes the group even when in_last = 0; the next operand starts a new group.
- An idle ACCUM (no in_valid) holds all state indefinitely.
- in_data and in_last are don't-care while in_valid = 0 or in_ready = 0.
- All arithmetic is mod 2^WIDTH. The final CPA carry-out is outside this block's scope.

Optional Feature:
- Macro CSA_OVF_EN.
- Defined:
  - Adds output port out_ovf, 1 bit, reset 0.
  - A sticky internal flag ORs in the discarded maj bit WIDTH-1 on every fire_in.
  - out_ovf presents the flag in HOLD and is valid with out_valid.
  - The flag clears on the out handshake or on reset.
  - It flags intermediate carry loss only.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, M=4 unless stated):
- Reset: rst_n=0 for 2 cycles with random in_valid -> out_valid=0, in_ready=1, out_s=out_c=0, out_count=0.
- Full group: 0x01, 0x02, 0x03, 0x04 back-to-back, in_last=0 -> next cycle out_valid=1, out_s=0x02, out_c=0x08, out_count=4, in_ready=0. With CSA_OVF_EN, out_ovf=0.
- Early close: 0xFF, then 0xFF with in_last=1 -> out_s=0x00, out_c=0xFE, out_count=2. With CSA_OVF_EN, out_ovf=1. Single 0x5A with in_last=1 -> out_s=0x5A, out_c=0x00, out_count=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> out_s, out_c and out_count stable; in_ready=0; no operand consumed. Then release out_ready -> in_ready=1 the next cycle, and the next group starts from s=c=0.
- Reset mid-group: accept 0x10 and 0x20, then rst_n=0 for 1 cycle, then group 0x07 with in_last=1 -> out_s=0x07, out_c=0x00, out_count=1.
- Random scoreboard: 10k random operands, in_last, in_valid and out_ready -> (out_s + out_c) mod 256 equals the reference group sum mod 256; out_count matches the operands accepted; no output change while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save accumulator feeding the m-operand carry-propagate adder
//
// Folds one operand per accepted cycle into a redundant (s, c) pair through a 3:2
// compressor.  When a group closes, the pair is held for the downstream carry-propagate
// adder; the group total is out_s + out_c mod 2^WIDTH.
//
// Parameters: WIDTH operand width, M max operands per group, CW = $clog2(M+1) (derived).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand stream handshake; in_data operand, in_last closes group
//   out_valid/out_ready   result handshake; out_s sum vector, out_c carry vector (bit 0 = 0),
//                         out_count operands in the presented group
//   out_ovf               (only with CSA_OVF_EN) sticky loss of an intermediate carry bit
// Optional feature macro: CSA_OVF_EN
module csa_accumulator #(
    parameter int WIDTH = 64,
    parameter int M     = 8,
    parameter int CW    = $clog2(M + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic [WIDTH-1:0] out_c,
`ifdef CSA_OVF_EN
    output logic             out_ovf,
`endif
    output logic [CW-1:0]    out_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  s, c;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_inc;
    logic [WIDTH-2:0]  maj_lo;
    logic              fire_in, fire_out, close_group;

    // Only the low WIDTH-1 majority bits survive the left shift into c; the top bit
    // is computed separately so it exists only when the overflow flag needs it.
    assign maj_lo = (s[WIDTH-2:0] & c[WIDTH-2:0])
                  | (s[WIDTH-2:0] & in_data[WIDTH-2:0])
                  | (c[WIDTH-2:0] & in_data[WIDTH-2:0]);

    assign count_inc   = count + CW'(1);
    assign fire_in     = in_valid & in_ready;
    assign fire_out    = out_valid & out_ready;
    // The M limit closes a group even without in_last.
    assign close_group = in_last | (count_inc == CW'(M));

`ifdef CSA_OVF_EN
    logic maj_hi;
    logic ovf;

    assign maj_hi = (s[WIDTH-1] & c[WIDTH-1])
                  | (s[WIDTH-1] & in_data[WIDTH-1])
                  | (c[WIDTH-1] & in_data[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (fire_in) begin
            ovf <= ovf | maj_hi;
        end else if (fire_out) begin
            ovf <= 1'b0;
        end
    end

    assign out_ovf = out_valid ? ovf : 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
            s     <= '0;
            c     <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            if (fire_in) begin
                s     <= s ^ c ^ in_data;
                c     <= {maj_lo, 1'b0};
                count <= count_inc;
            end else if (fire_out) begin
                s     <= '0;
                c     <= '0;
                count <= '0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && close_group) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ACCUM;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    // Outputs read as zero outside HOLD so a partial accumulation is never exposed.
    assign out_s     = out_valid ? s     : '0;
    assign out_c     = out_valid ? c     : '0;
    assign out_count = out_valid ? count : '0;

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - self-checking bench for csa_accumulator (WIDTH=8, M=4)
module tb_csa_accumulator;

    localparam int WIDTH = 8;
    localparam int M     = 4;
    localparam int CW    = $clog2(M + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic [WIDTH-1:0] out_c;
    logic [CW-1:0]    out_count;
`ifdef CSA_OVF_EN
    logic             out_ovf;
`endif

    csa_accumulator #(.WIDTH(WIDTH), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
`ifdef CSA_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a group is a plain arithmetic sum of accepted operands.
    logic             m_hold = 1'b0;
    logic [WIDTH-1:0] m_sum  = '0;
    int               m_cnt  = 0;
    int               m_acc  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hold <= 1'b0;
            m_sum  <= '0;
            m_cnt  <= 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                m_sum <= m_sum + in_data;
                m_cnt <= m_cnt + 1;
                m_acc <= m_acc + 1;
                if (in_last || (m_cnt + 1 == M)) m_hold <= 1'b1;
            end
        end else if (out_ready) begin
            m_hold <= 1'b0;
            m_sum  <= '0;
            m_cnt  <= 0;
        end
    end

    // Per-cycle compare against the model, plus stability while stalled.
    logic             chk_en = 1'b0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_s, prev_c;
    logic [CW-1:0]    prev_cnt;
    logic [WIDTH-1:0] tot;

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_hold));
            chk("in_ready", 32'(in_ready), 32'(!m_hold));
            if (m_hold) begin
                tot = out_s + out_c;
                chk("group_total", 32'(tot), 32'(m_sum));
                chk("out_count", 32'(out_count), 32'(m_cnt));
                chk("out_c_bit0", 32'(out_c[0]), 32'd0);
            end
            if (prev_stall && out_valid) begin
                chk("stable_s", 32'(out_s), 32'(prev_s));
                chk("stable_c", 32'(out_c), 32'(prev_c));
                chk("stable_count", 32'(out_count), 32'(prev_cnt));
            end
            prev_stall <= out_valid && !out_ready;
            prev_s     <= out_s;
            prev_c     <= out_c;
            prev_cnt   <= out_count;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic expect_group(input string tag, input logic [WIDTH-1:0] es,
                                input logic [WIDTH-1:0] ec, input int ecnt);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_s"}, 32'(out_s), 32'(es));
        chk({tag, "_c"}, 32'(out_c), 32'(ec));
        chk({tag, "_count"}, 32'(out_count), 32'(ecnt));
    endtask

    initial begin
        int target;
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 8'($urandom);
        in_last   = 1'($urandom_range(0, 1));
        out_ready = 1'b0;

        // Reset with random in_valid
        @(posedge clk);
        #1;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_s", 32'(out_s), 32'd0);
        chk("rst_out_c", 32'(out_c), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
`ifdef CSA_OVF_EN
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_en   = 1'b1;
        @(posedge clk);
        #1;

        // Full group closed by the M limit
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        expect_group("full", 8'h02, 8'h08, 4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("model_full_sum", 32'(m_sum), 32'd10);
`ifdef CSA_OVF_EN
        chk("full_ovf", 32'(out_ovf), 32'd0);
`endif

        // Backpressure: in_valid held high, nothing may be consumed
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_s", 32'(out_s), 32'h02);
        chk("bp_c", 32'(out_c), 32'h08);
        chk("bp_count", 32'(out_count), 32'd4);
        release_out();
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Early close with carry loss, then a one-operand group
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        expect_group("early", 8'h00, 8'hFE, 2);
        chk("model_early_sum", 32'(m_sum), 32'hFE);
`ifdef CSA_OVF_EN
        chk("early_ovf", 32'(out_ovf), 32'd1);
`endif
        release_out();
        send(8'h5A, 1'b1);
        expect_group("single", 8'h5A, 8'h00, 1);
`ifdef CSA_OVF_EN
        chk("single_ovf", 32'(out_ovf), 32'd0);
`endif
        release_out();

        // Reset mid-group discards the partial accumulation
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h07, 1'b1);
        expect_group("midrst", 8'h07, 8'h00, 1);
        release_out();

        // Random traffic against the model
        target = m_acc + 10000;
        cyc = 0;
        while (m_acc < target && cyc < 50000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("random_budget", 32'(m_acc >= target), 32'd1);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
